led_bank_pwm: RTL

LED_BANK_PWM -- requirements
Module: led_bank_pwm

---
 rtl/led_bank_pwm_if.sv | 29 ++
 rtl/led_bank_pwm.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/led_bank_pwm_if.sv
// Control/status bundle for led_bank_pwm: counter controls, channel write port
// and the registered LED drive/enable, tick and counter outputs.
interface led_bank_pwm_if #(
    parameter int CHANNELS = 4,
    parameter int PWM_BITS = 8
);
    localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic                count_clr;
    logic                count_hold;
    logic                wr_en;
    logic [SEL_W-1:0]    wr_sel;
    logic [1:0]          wr_mode;
    logic [PWM_BITS-1:0] wr_duty;
    logic [CHANNELS-1:0] led_out;
    logic [CHANNELS-1:0] led_oe;
    logic                tick;
    logic [CHANNELS-1:0] count;

    modport master (
        output count_clr, count_hold, wr_en, wr_sel, wr_mode, wr_duty,
        input  led_out, led_oe, tick, count
    );

    modport slave (
        input  count_clr, count_hold, wr_en, wr_sel, wr_mode, wr_duty,
        output led_out, led_oe, tick, count
    );
endinterface

// File: rtl/led_bank_pwm.sv
// LED bank driver: prescaled binary counter plus a shared PWM counter, with a
// per-channel mode/duty block producing registered SB_IO drive and enable.

module led_bank_pwm_ch #(
    parameter int         PWM_BITS   = 8,
    parameter logic [1:0] MODE_RESET = 2'b01
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                i_wr,
    input  logic [1:0]          i_mode,
    input  logic [PWM_BITS-1:0] i_duty,
    input  logic [PWM_BITS-1:0] i_pwm,
    input  logic                i_pwm_wrap,
    input  logic                i_cnt_bit,
    output logic                o_led,
    output logic                o_oe
);
    typedef enum logic [1:0] {
        M_OFF = 2'b00,
        M_CNT = 2'b01,
        M_PWM = 2'b10,
        M_ON  = 2'b11
    } mode_t;

    mode_t               r_mode;
    logic [PWM_BITS-1:0] r_shadow;
    logic [PWM_BITS-1:0] r_active;
    logic                r_led;
    logic                r_oe;
    logic                w_led;
    logic                w_oe;

    always_comb begin
        w_led = 1'b0;
        w_oe  = 1'b0;
        case (r_mode)
            M_OFF: begin w_oe = 1'b0; w_led = 1'b0;               end
            M_CNT: begin w_oe = 1'b1; w_led = i_cnt_bit;          end
            M_PWM: begin w_oe = 1'b1; w_led = (i_pwm < r_active); end
            M_ON:  begin w_oe = 1'b1; w_led = 1'b1;               end
            default: begin w_oe = 1'b0; w_led = 1'b0;             end
        endcase
    end

    // Active duty samples the pre-edge shadow on the wrap edge, so a write
    // landing in the wrap cycle only shows up one period later.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_mode   <= mode_t'(MODE_RESET);
            r_shadow <= '0;
            r_active <= '0;
            r_led    <= 1'b0;
            r_oe     <= 1'b0;
        end else begin
            if (i_wr) begin
                r_mode   <= mode_t'(i_mode);
                r_shadow <= i_duty;
            end
            if (i_pwm_wrap)
                r_active <= r_shadow;
            r_led <= w_led;
            r_oe  <= w_oe;
        end
    end

    assign o_led = r_led;
    assign o_oe  = r_oe;
endmodule

module led_bank_pwm #(
    parameter int         CLK_HZ     = 24000000,
    parameter int         TICK_HZ    = 1,
    parameter int         CHANNELS   = 4,
    parameter int         PWM_BITS   = 8,
    parameter logic [1:0] MODE_RESET = 2'b01
) (
    input  logic        clk,
    input  logic        resetn,
    led_bank_pwm_if.slave bus
);
    localparam int DIV   = CLK_HZ / TICK_HZ;
    localparam int PRE_W = $clog2(DIV);
    localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(DIV - 1);

    logic [PRE_W-1:0]    r_pre;
    logic                r_tick;
    logic [CHANNELS-1:0] r_count;
    logic [PWM_BITS-1:0] r_pwm;
    logic                w_pre_wrap;
    logic                w_pwm_wrap;
    logic                w_sel_ok;
    logic [CHANNELS-1:0] w_wr;
    logic [CHANNELS-1:0] w_led;
    logic [CHANNELS-1:0] w_oe;

    assign w_pre_wrap = (r_pre == PRE_MAX);
    assign w_pwm_wrap = &r_pwm;
    assign w_sel_ok   = (int'(bus.wr_sel) < CHANNELS);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_pre  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_tick <= w_pre_wrap;
            r_pre  <= w_pre_wrap ? '0 : r_pre + 1'b1;
        end
    end

    // Clear wins over both the tick and the hold.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            r_count <= '0;
        else if (bus.count_clr)
            r_count <= '0;
        else if (r_tick && !bus.count_hold)
            r_count <= r_count + 1'b1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            r_pwm <= '0;
        else
            r_pwm <= r_pwm + 1'b1;
    end

    genvar i;
    generate
        for (i = 0; i < CHANNELS; i++) begin : g_ch
            assign w_wr[i] = bus.wr_en && w_sel_ok && (bus.wr_sel == SEL_W'(i));

            led_bank_pwm_ch #(
                .PWM_BITS   (PWM_BITS),
                .MODE_RESET (MODE_RESET)
            ) u_ch (
                .clk        (clk),
                .resetn     (resetn),
                .i_wr       (w_wr[i]),
                .i_mode     (bus.wr_mode),
                .i_duty     (bus.wr_duty),
                .i_pwm      (r_pwm),
                .i_pwm_wrap (w_pwm_wrap),
                .i_cnt_bit  (r_count[i]),
                .o_led      (w_led[i]),
                .o_oe       (w_oe[i])
            );
        end
    endgenerate

    assign bus.led_out = w_led;
    assign bus.led_oe  = w_oe;
    assign bus.tick    = r_tick;
    assign bus.count   = r_count;
endmodule
